// File: rtl/warpv_pcpi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : warpv_pcpi_pkg
// Description : Shared types and constants for the PCPI issue/collect slice:
//               controller state encoding, RV32 M-extension opcode fields,
//               the default claim timeout and the merged result record.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package warpv_pcpi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] F7_MULDIV  = 7'b0000001;
  localparam int         TIMEOUT_DEFAULT = 16;

  // Merged co-processor answer as presented to the core.
  typedef struct packed {
    logic        wr;
    logic [31:0] rd;
    logic        illegal;
  } result_t;

  // True for any RV32M instruction (MUL*/DIV*/REM*).
  function automatic logic is_muldiv(input logic [31:0] insn);
    return (insn[6:0] == OPC_OP) && (insn[31:25] == F7_MULDIV);
  endfunction

endpackage
`default_nettype wire

// File: rtl/warpv_pcpi_timeout.sv
`default_nettype none
// ============================================================================
// Module      : warpv_pcpi_timeout
// Description : Claim-timeout counter for the PCPI issue controller. Counts
//               cycles spent in ISSUE with nobody claiming the instruction.
//               A claim (wait) clears the count and holds it at zero.
// Ports       : clk, resetn  - clock, synchronous active-low reset
//               active       - controller is in ISSUE
//               hold         - some co-processor asserts wait
//               expire       - count reached TIMEOUT-1 with no wait
// Revision    : 1.0 - initial release
// ============================================================================
module warpv_pcpi_timeout
  import warpv_pcpi_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic resetn,
  input  logic active,
  input  logic hold,
  output logic expire
);

  localparam int             CW          = 8;
  localparam logic [CW-1:0]  C_LAST_COUNT = CW'(TIMEOUT - 1);

  logic [CW-1:0] r_count;

  // Outside ISSUE the count sits at zero, so entering ISSUE always starts
  // from a cleared counter without needing an explicit entry pulse.
  always_ff @(posedge clk) begin
    if (!resetn || !active || hold) begin
      r_count <= '0;
    end else if (r_count != C_LAST_COUNT) begin
      r_count <= r_count + CW'(1);
    end
  end

  assign expire = active && !hold && (r_count == C_LAST_COUNT);

endmodule
`default_nettype wire

// File: rtl/warpv_pcpi_issue.sv
`default_nettype none
// ============================================================================
// Module      : warpv_pcpi_issue
// Description : Core-side PCPI issue/collect controller in front of the fast
//               multiplier and divider. Registers one instruction, drives
//               pcpi_valid until a co-processor answers, returns the merged
//               result under res_ready backpressure, and reports an illegal
//               instruction when nobody claims it within TIMEOUT cycles.
// Config      : `define PCPI_RESULT_BYPASS_EN to present the co-processor
//               result combinationally in the ready cycle (saves one cycle
//               when res_ready is already high).
// Ports       : clk, resetn                  - clock, sync active-low reset
//               iss_valid/iss_ready/iss_*    - instruction from the core
//               pcpi_valid/pcpi_insn/rs1/rs2 - request to co-processors
//               mul_*, div_*                 - co-processor answers
//               res_valid/res_ready/res_*    - result back to the core
// Revision    : 1.0 - initial release
// ============================================================================
module warpv_pcpi_issue
  import warpv_pcpi_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT,
  parameter bit HAS_DIV = 1'b1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        iss_valid,
  output logic        iss_ready,
  input  logic [31:0] iss_insn,
  input  logic [31:0] iss_rs1,
  input  logic [31:0] iss_rs2,
  output logic        pcpi_valid,
  output logic [31:0] pcpi_insn,
  output logic [31:0] pcpi_rs1,
  output logic [31:0] pcpi_rs2,
  input  logic        mul_wr,
  input  logic [31:0] mul_rd,
  input  logic        mul_wait,
  input  logic        mul_ready,
  input  logic        div_wr,
  input  logic [31:0] div_rd,
  input  logic        div_wait,
  input  logic        div_ready,
  output logic        res_valid,
  input  logic        res_ready,
  output logic        res_wr,
  output logic [31:0] res_rd,
  output logic        res_illegal
);

  state_t      r_state, w_state_nxt;
  result_t     r_res, w_res_nxt, w_src;
  logic        w_capture;
  logic        w_div_wr, w_div_wait, w_div_ready;
  logic [31:0] w_div_rd;
  logic        w_ready, w_wait, w_in_issue, w_expire;

  generate
    if (HAS_DIV) begin : g_div
      assign w_div_wr    = div_wr;
      assign w_div_rd    = div_rd;
      assign w_div_wait  = div_wait;
      assign w_div_ready = div_ready;
    end else begin : g_no_div
      assign w_div_wr    = 1'b0;
      assign w_div_rd    = '0;
      assign w_div_wait  = 1'b0;
      assign w_div_ready = 1'b0;
    end
  endgenerate

  assign w_in_issue = (r_state == ISSUE);
  assign w_ready    = mul_ready | w_div_ready;
  assign w_wait     = mul_wait  | w_div_wait;

  // Multiplier has priority when both answer in the same cycle.
  always_comb begin
    w_src.wr      = mul_ready ? mul_wr : w_div_wr;
    w_src.rd      = mul_ready ? mul_rd : w_div_rd;
    w_src.illegal = 1'b0;
  end

  warpv_pcpi_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk    (clk),
    .resetn (resetn),
    .active (w_in_issue),
    .hold   (w_wait),
    .expire (w_expire)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= IDLE;
      r_res   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_res   <= w_res_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      pcpi_insn <= '0;
      pcpi_rs1  <= '0;
      pcpi_rs2  <= '0;
    end else if (w_capture) begin
      pcpi_insn <= iss_insn;
      pcpi_rs1  <= iss_rs1;
      pcpi_rs2  <= iss_rs2;
    end
  end

  // Next state and outputs. pcpi_valid comes straight off the state flop, so
  // it drops the cycle after ready: the fast multiplier would otherwise
  // start a second operation.
  always_comb begin
    w_state_nxt = r_state;
    w_res_nxt   = r_res;
    w_capture   = 1'b0;
    iss_ready   = 1'b0;
    pcpi_valid  = 1'b0;
    res_valid   = 1'b0;
    res_wr      = 1'b0;
    res_rd      = '0;
    res_illegal = 1'b0;

    case (r_state)
      IDLE: begin
        iss_ready = 1'b1;
        if (iss_valid) begin
          w_capture   = 1'b1;
          w_state_nxt = ISSUE;
        end
      end

      ISSUE: begin
        pcpi_valid = 1'b1;
        // Ready takes precedence over a timeout in the same cycle.
        if (w_ready) begin
          w_res_nxt = w_src;
`ifdef PCPI_RESULT_BYPASS_EN
          res_valid = 1'b1;
          res_wr    = w_src.wr;
          res_rd    = w_src.rd;
          w_state_nxt = res_ready ? IDLE : DONE;
`else
          w_state_nxt = DONE;
`endif
        end else if (w_expire) begin
          w_res_nxt.wr      = 1'b0;
          w_res_nxt.rd      = '0;
          w_res_nxt.illegal = 1'b1;
          w_state_nxt       = DONE;
        end
      end

      DONE: begin
        res_valid   = 1'b1;
        res_wr      = r_res.wr;
        res_rd      = r_res.rd;
        res_illegal = r_res.illegal;
        if (res_ready) begin
          w_state_nxt = IDLE;
        end
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_warpv_pcpi_issue.sv
`default_nettype none
// ============================================================================
// Module      : tb_warpv_pcpi_issue
// Description : Self-checking bench for warpv_pcpi_issue. Expected results
//               are queued when an instruction is issued and popped when the
//               controller presents res_valid.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_warpv_pcpi_issue;
  import warpv_pcpi_pkg::*;

`ifdef PCPI_RESULT_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  localparam logic [31:0] C_MUL_INSN  = 32'h022081B3;
  localparam logic [31:0] C_DIVU_INSN = 32'h0220D1B3;
  localparam logic [31:0] C_BAD_INSN  = 32'h0000000B;

  logic        clk, resetn;
  logic        iss_valid, iss_ready;
  logic [31:0] iss_insn, iss_rs1, iss_rs2;
  logic        pcpi_valid;
  logic [31:0] pcpi_insn, pcpi_rs1, pcpi_rs2;
  logic        mul_wr, mul_wait, mul_ready;
  logic [31:0] mul_rd;
  logic        div_wr, div_wait, div_ready;
  logic [31:0] div_rd;
  logic        res_valid, res_ready, res_wr, res_illegal;
  logic [31:0] res_rd;

  int      n_tests = 0;
  int      n_fail  = 0;
  result_t q_exp[$];

  warpv_pcpi_issue #(.TIMEOUT(16), .HAS_DIV(1'b1)) dut (
    .clk(clk), .resetn(resetn),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_insn(iss_insn),
    .iss_rs1(iss_rs1), .iss_rs2(iss_rs2),
    .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn),
    .pcpi_rs1(pcpi_rs1), .pcpi_rs2(pcpi_rs2),
    .mul_wr(mul_wr), .mul_rd(mul_rd), .mul_wait(mul_wait), .mul_ready(mul_ready),
    .div_wr(div_wr), .div_rd(div_rd), .div_wait(div_wait), .div_ready(div_ready),
    .res_valid(res_valid), .res_ready(res_ready), .res_wr(res_wr),
    .res_rd(res_rd), .res_illegal(res_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    iss_valid = 0; iss_insn = 0; iss_rs1 = 0; iss_rs2 = 0;
    mul_wr = 0; mul_rd = 0; mul_wait = 0; mul_ready = 0;
    div_wr = 0; div_rd = 0; div_wait = 0; div_ready = 0;
    res_ready = 0;
  endtask

  // Present one instruction in the current (IDLE) cycle; returns in cycle 1.
  task automatic issue(input logic [31:0] insn, input logic [31:0] a, input logic [31:0] b);
    iss_valid = 1; iss_insn = insn; iss_rs1 = a; iss_rs2 = b;
    nxt();
    iss_valid = 0; iss_insn = 0; iss_rs1 = 0; iss_rs2 = 0;
  endtask

  task automatic test_reset();
    resetn = 0;
    clear_inputs();
    nxt(); nxt();
    #2;
    n_tests++;
    if ({iss_ready, pcpi_valid, res_valid, res_wr, res_illegal} !== 5'b10000) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b want 10000", {iss_ready, pcpi_valid, res_valid, res_wr, res_illegal});
    end
    n_tests++;
    if ({res_rd, pcpi_insn, pcpi_rs1, pcpi_rs2} !== 128'd0) begin
      n_fail++;
      $display("FAIL reset_data: res_rd=%h pcpi_insn=%h want 0", res_rd, pcpi_insn);
    end
    resetn = 1;
    nxt();
    #2;
    n_tests++;
    if (iss_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_iss_ready: got %b want 1", iss_ready);
    end
  endtask

  task automatic test_mul();
    result_t e;
    #2;
    n_tests++;
    if (iss_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL mul_iss_ready_idle: got %b want 1", iss_ready);
    end
    q_exp.push_back('{wr: 1'b1, rd: 32'd42, illegal: 1'b0});
    issue(C_MUL_INSN, 32'd7, 32'd6);
    for (int c = 1; c <= 3; c++) begin
      if (c == 3) begin
        mul_ready = 1; mul_wr = 1; mul_rd = pcpi_rs1 * pcpi_rs2;
      end
      #2;
      n_tests++;
      if ({pcpi_valid, iss_ready} !== 2'b10 || pcpi_insn !== C_MUL_INSN) begin
        n_fail++;
        $display("FAIL mul_pcpi_valid_c%0d: valid=%b iss_ready=%b insn=%h want 1 0 %h",
                 c, pcpi_valid, iss_ready, pcpi_insn, C_MUL_INSN);
      end
      if (c == 3) begin
        n_tests++;
        if (res_valid !== BYP) begin
          n_fail++;
          $display("FAIL mul_res_valid_c3: got %b want %b", res_valid, BYP);
        end
      end
      nxt();
    end
    mul_ready = 0; mul_wr = 0; mul_rd = 0;
    #2;
    n_tests++;
    if ({pcpi_valid, res_valid} !== 2'b01) begin
      n_fail++;
      $display("FAIL mul_c4: pcpi_valid=%b res_valid=%b want 0 1", pcpi_valid, res_valid);
    end
    n_tests++;
    if (q_exp.size() == 0) begin
      n_fail++;
      $display("FAIL mul_result: scoreboard empty");
    end else begin
      e = q_exp.pop_front();
      if ({res_wr, res_rd, res_illegal} !== e) begin
        n_fail++;
        $display("FAIL mul_result: got wr=%b rd=%h ill=%b want wr=%b rd=%h ill=%b",
                 res_wr, res_rd, res_illegal, e.wr, e.rd, e.illegal);
      end
    end
    res_ready = 1;
    nxt();
    res_ready = 0;
    #2;
    n_tests++;
    if ({iss_ready, res_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL mul_back_idle: iss_ready=%b res_valid=%b want 1 0", iss_ready, res_valid);
    end
  endtask

  task automatic test_div_wait();
    result_t e;
    bit bad;
    bad = 0;
    q_exp.push_back('{wr: 1'b1, rd: 32'h5, illegal: 1'b0});
    issue(C_DIVU_INSN, 32'd35, 32'd7);
    div_wait = 1;
    for (int c = 0; c < 20; c++) begin
      #2;
      if (pcpi_valid !== 1'b1 || res_valid !== 1'b0) bad = 1;
      nxt();
    end
    div_wait = 0; div_ready = 1; div_wr = 1; div_rd = 32'h5;
    nxt();
    div_ready = 0; div_wr = 0; div_rd = 0;
    n_tests++;
    if (bad) begin
      n_fail++;
      $display("FAIL div_wait_hold: early exit during wait, got 1 want 0");
    end
    #2;
    n_tests++;
    if (q_exp.size() == 0 || res_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL div_result: res_valid=%b want 1", res_valid);
    end else begin
      e = q_exp.pop_front();
      if ({res_wr, res_rd, res_illegal} !== e) begin
        n_fail++;
        $display("FAIL div_result: got wr=%b rd=%h ill=%b want wr=%b rd=%h ill=%b",
                 res_wr, res_rd, res_illegal, e.wr, e.rd, e.illegal);
      end
    end
    res_ready = 1;
    nxt();
    res_ready = 0;
  endtask

  task automatic test_timeout();
    result_t e;
    int n;
    n = 0;
    q_exp.push_back('{wr: 1'b0, rd: 32'h0, illegal: 1'b1});
    issue(C_BAD_INSN, 32'h1234, 32'h5678);
    #2;
    while (pcpi_valid === 1'b1 && n < 40) begin
      n++;
      nxt();
      #2;
    end
    n_tests++;
    if (n != 16) begin
      n_fail++;
      $display("FAIL timeout_cycles: got %0d ISSUE cycles want 16", n);
    end
    n_tests++;
    if (q_exp.size() == 0 || res_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_result: res_valid=%b want 1", res_valid);
    end else begin
      e = q_exp.pop_front();
      if ({res_wr, res_rd, res_illegal} !== e) begin
        n_fail++;
        $display("FAIL timeout_result: got wr=%b rd=%h ill=%b want wr=%b rd=%h ill=%b",
                 res_wr, res_rd, res_illegal, e.wr, e.rd, e.illegal);
      end
    end
    res_ready = 1;
    nxt();
    res_ready = 0;
  endtask

  task automatic test_simultaneous();
    result_t e;
    bit bad;
    bad = 0;
    q_exp.push_back('{wr: 1'b1, rd: 32'h11, illegal: 1'b0});
    issue(C_MUL_INSN, 32'd2, 32'd3);
    nxt(); nxt();
    mul_ready = 1; mul_wr = 1; mul_rd = 32'h11;
    div_ready = 1; div_wr = 1; div_rd = 32'h22;
    nxt();
    clear_inputs();
    for (int c = 0; c < 5; c++) begin
      #2;
      if (res_valid !== 1'b1 || res_rd !== 32'h11 || res_wr !== 1'b1 ||
          iss_ready !== 1'b0 || pcpi_valid !== 1'b0) bad = 1;
      nxt();
    end
    n_tests++;
    if (bad) begin
      n_fail++;
      $display("FAIL simul_stall_stable: res_* not held, got 1 want 0");
    end
    #2;
    n_tests++;
    if (q_exp.size() == 0) begin
      n_fail++;
      $display("FAIL simul_result: scoreboard empty");
    end else begin
      e = q_exp.pop_front();
      if ({res_wr, res_rd, res_illegal} !== e) begin
        n_fail++;
        $display("FAIL simul_result: got wr=%b rd=%h ill=%b want wr=%b rd=%h ill=%b",
                 res_wr, res_rd, res_illegal, e.wr, e.rd, e.illegal);
      end
    end
    res_ready = 1;
    nxt();
    res_ready = 0;
  endtask

  task automatic test_reset_mid();
    bit bad;
    bad = 0;
    issue(C_MUL_INSN, 32'd9, 32'd9);
    nxt();
    resetn = 0;
    nxt();
    resetn = 1;
    nxt();
    mul_ready = 1; mul_wr = 1; mul_rd = 32'd81;
    for (int c = 0; c < 4; c++) begin
      #2;
      if (iss_ready !== 1'b1 || res_valid !== 1'b0 || pcpi_valid !== 1'b0) bad = 1;
      nxt();
      mul_ready = 0; mul_wr = 0; mul_rd = 0;
    end
    n_tests++;
    if (bad) begin
      n_fail++;
      $display("FAIL reset_mid: late ready not ignored, got 1 want 0");
    end
  endtask

  // Stream of MULs with res_ready held high; a fast-mul model answers on the
  // third pcpi_valid cycle.
  task automatic test_back_to_back();
    result_t e;
    logic [31:0] a[3], b[3];
    int acc[3];
    int sent, got, vcnt;
    a = '{32'd3, 32'd100, 32'hFFFF_FFFF};
    b = '{32'd4, 32'd7,   32'd2};
    sent = 0; got = 0; vcnt = 0;
    res_ready = 1;
    for (int c = 0; c < 60 && got < 3; c++) begin
      iss_valid = (sent < 3) && (iss_ready === 1'b1);
      if (iss_valid) begin
        iss_insn = C_MUL_INSN; iss_rs1 = a[sent]; iss_rs2 = b[sent];
        q_exp.push_back('{wr: 1'b1, rd: a[sent] * b[sent], illegal: 1'b0});
        acc[sent] = c;
        sent++;
      end
      vcnt      = (pcpi_valid === 1'b1) ? vcnt + 1 : 0;
      mul_ready = (vcnt == 3);
      mul_wr    = mul_ready;
      mul_rd    = mul_ready ? pcpi_rs1 * pcpi_rs2 : 32'd0;
      #2;
      if (res_valid === 1'b1) begin
        got++;
        n_tests++;
        if (q_exp.size() == 0) begin
          n_fail++;
          $display("FAIL b2b_result%0d: scoreboard empty", got);
        end else begin
          e = q_exp.pop_front();
          if ({res_wr, res_rd, res_illegal} !== e) begin
            n_fail++;
            $display("FAIL b2b_result%0d: got wr=%b rd=%h ill=%b want wr=%b rd=%h ill=%b",
                     got, res_wr, res_rd, res_illegal, e.wr, e.rd, e.illegal);
          end
        end
      end
      nxt();
    end
    clear_inputs();
    n_tests++;
    if (got != 3) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d results want 3", got);
    end else begin
      for (int k = 1; k < 3; k++) begin
        n_tests++;
        if (acc[k] - acc[k-1] != (BYP ? 4 : 5)) begin
          n_fail++;
          $display("FAIL b2b_spacing%0d: got %0d cycles want %0d", k, acc[k] - acc[k-1], BYP ? 4 : 5);
        end
      end
    end
  endtask

`ifdef PCPI_RESULT_BYPASS_EN
  task automatic test_bypass();
    result_t e;
    q_exp.push_back('{wr: 1'b1, rd: 32'd12, illegal: 1'b0});
    issue(C_MUL_INSN, 32'd3, 32'd4);
    nxt(); nxt();
    res_ready = 1;
    mul_ready = 1; mul_wr = 1; mul_rd = pcpi_rs1 * pcpi_rs2;
    #2;
    n_tests++;
    if (q_exp.size() == 0 || res_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL bypass_c3: res_valid=%b want 1", res_valid);
    end else begin
      e = q_exp.pop_front();
      if ({res_wr, res_rd, res_illegal} !== e) begin
        n_fail++;
        $display("FAIL bypass_c3: got rd=%h want %h", res_rd, e.rd);
      end
    end
    nxt();
    clear_inputs();
    #2;
    n_tests++;
    if ({iss_ready, pcpi_valid, res_valid} !== 3'b100) begin
      n_fail++;
      $display("FAIL bypass_c4: got %b want 100", {iss_ready, pcpi_valid, res_valid});
    end
  endtask
`endif

  initial begin
    test_reset();
    test_mul();
    test_div_wait();
    test_timeout();
    test_simultaneous();
    test_reset_mid();
    test_back_to_back();
`ifdef PCPI_RESULT_BYPASS_EN
    test_bypass();
`endif
    n_tests++;
    if (q_exp.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d leftover want 0", q_exp.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/warpv_pcpi_issue.md
Name: warpv_pcpi_issue

Overview:
- Core-side PCPI issue/collect controller sitting directly upstream of the fast multiplier and the divider co-processors.
- Accepts one custom/M-extension instruction at a time from the core and registers insn and operands.
- Drives pcpi_valid until one co-processor answers, then merges and returns the result with backpressure.
- Flags the instruction illegal if no co-processor claims it within a timeout.

Parameters:
- TIMEOUT, 16, cycles pcpi_valid may stay high with no wait/ready before the illegal flag fires (range 2..255).
- HAS_DIV, 1, 0 ties all div_* inputs to inactive internally.

Ports:
- clk  in  1  clock
- resetn  in  1  reset
- iss_valid  in  1  core presents an instruction
- iss_ready  out  1  controller can accept (IDLE)
- iss_insn  in  32  instruction word
- iss_rs1  in  32  operand 1
- iss_rs2  in  32  operand 2
- pcpi_valid  out  1  to co-processors
- pcpi_insn  out  32  registered insn
- pcpi_rs1  out  32  registered rs1
- pcpi_rs2  out  32  registered rs2
- mul_wr  in  1  mul result writes rd
- mul_rd  in  32  mul result
- mul_wait  in  1  mul claims, still busy
- mul_ready  in  1  mul done
- div_wr  in  1  div result writes rd
- div_rd  in  32  div result
- div_wait  in  1  div claims, still busy
- div_ready  in  1  div done
- res_valid  out  1  result available
- res_ready  in  1  core consumes result
- res_wr  out  1  result writes rd
- res_rd  out  32  result data
- res_illegal  out  1  timeout, no claimant

Behaviour:
- Reset: clk and resetn, resetn is synchronous, active-low. Reset forces IDLE and drives all outputs 0 except iss_ready=1. Reset mid-operation abandons the op; late mul/div ready is ignored.
- States:
  - IDLE: iss_ready=1. On iss_valid, capture insn/rs1/rs2 and go to ISSUE.
  - ISSUE: pcpi_valid=1, registered, first high the cycle after acceptance. Operands are held stable.
  - DONE: res_valid=1. Hold res_* until res_ready, then go to IDLE; iss_ready=1 that same next cycle.
- ISSUE exit on ready:
  - A cycle with mul_ready|div_ready latches wr/rd from the ready source and goes to DONE.
  - pcpi_valid is low the following cycle. This is mandatory: the fast multiplier re-launches if valid persists.
- Simultaneous readies: mul wins; div result is discarded.
- Timeout counter:
  - Clears on entry to ISSUE and increments each ISSUE cycle with no wait/ready.
  - Any mul_wait|div_wait clears it and holds it at 0 while asserted.
  - On reaching TIMEOUT-1 without ready: go to DONE with res_illegal=1, res_wr=0, res_rd=0.
- ready and timeout in the same cycle: ready wins.
- Latency, no bypass, fast mul without extra FFs:
  - Accept at cycle 0, pcpi_valid at cycle 1, mul_ready at cycle 3, res_valid at cycle 4.
  - Back-to-back throughput: one op per 5 cycles with res_ready=1.
- ready seen outside ISSUE is ignored.

Optional Feature:
- Macro PCPI_RESULT_BYPASS_EN.
- Defined: in ISSUE, res_valid/res_wr/res_rd are driven combinationally from the ready source in the ready cycle.
  - If res_ready is also high, go straight to IDLE, saving 1 cycle (mul result at cycle 3).
  - Otherwise capture and go to DONE as normal.
  - The timeout path still goes through DONE.
- Undefined: all res_* are registered (DONE only), as above.

Decomposition:
- Package warpv_pcpi_pkg:
  - state enum {IDLE, ISSUE, DONE}
  - OPC_OP=7'b0110011, F7_MULDIV=7'b0000001
  - TIMEOUT_DEFAULT=16
  - result struct {wr, rd[31:0], illegal}
- Sub-module warpv_pcpi_timeout: counter with clear/hold/expire, parameter TIMEOUT.

Test Plan:
- MUL with rs1=7, rs2=6, fast-mul model → pcpi_valid cycles 1-3 then low; res_valid at cycle 4; res_rd=42, res_wr=1, res_illegal=0.
- DIV model asserting wait for 20 cycles then ready with rd=0x5 → no timeout despite 20>16; res_rd=5 one cycle after ready.
- Unclaimed insn 0x0000000B with no wait/ready → res_illegal=1, res_wr=0 after exactly 16 ISSUE cycles; pcpi_valid low next cycle.
- mul_ready and div_ready same cycle (rd 0x11 / 0x22) → res_rd=0x11; res_ready held low 5 cycles → res_* stable, iss_ready=0 throughout.
- resetn low during ISSUE, then mul_ready 1 cycle after release → state IDLE, res_valid stays 0, iss_ready=1.
- PCPI_RESULT_BYPASS_EN with res_ready=1, MUL 3×4 → res_valid at cycle 3 with res_rd=12; next accept at cycle 4.
